// File: rtl/tx_burst_sequencer_if.sv
// Bus between the scan/control logic and the transmit burst sequencer.
// start_in is a single-cycle request, taken only while busy_out is low; busy_out rises the next cycle to acknowledge it.
interface tx_burst_sequencer_if #(
    parameter int NUM_CH = 8,
    parameter int OW     = 12
);
    logic                 start_in;
    logic                 abort_in;
    logic [OW-1:0]        steer_delay_in;
    logic                 steer_dir_in;
    logic [NUM_CH*OW-1:0] offsets_out;
    logic                 pwm_rst_out;
    logic                 tx_en_out;
    logic                 listen_out;
    logic                 busy_out;
    logic                 done_out;
    logic [2:0]           state_dbg;

    modport master (
        output start_in, abort_in, steer_delay_in, steer_dir_in,
        input  offsets_out, pwm_rst_out, tx_en_out, listen_out, busy_out, done_out, state_dbg
    );

    modport slave (
        input  start_in, abort_in, steer_delay_in, steer_dir_in,
        output offsets_out, pwm_rst_out, tx_en_out, listen_out, busy_out, done_out, state_dbg
    );
endinterface

// File: rtl/tx_burst_sequencer.sv
// Beam-steered transmit burst sequencer: loads per-channel PWM phase offsets,
// releases the PWM bank for NUM_PULSES carrier periods, then holds a listen window.
module tx_burst_sequencer #(
    parameter int NUM_CH                 = 8,
    parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
    parameter int NUM_PULSES             = 8,
    parameter int LISTEN_CYCLES          = 2500000
) (
    input logic                  clk_in,
    input logic                  rst_in,
    tx_burst_sequencer_if.slave  bus
);
    localparam int OW  = $clog2(PERIOD_IN_CLOCK_CYCLES);
    localparam int OW1 = OW + 1;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BURST_LEN = NUM_PULSES * PERIOD_IN_CLOCK_CYCLES;
    localparam int BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LW  = (LISTEN_CYCLES > 1) ? $clog2(LISTEN_CYCLES) : 1;

    localparam logic [OW-1:0]  PERIOD_M1   = OW'(PERIOD_IN_CLOCK_CYCLES - 1);
    localparam logic [OW:0]    PERIOD_W    = OW1'(PERIOD_IN_CLOCK_CYCLES);
    localparam logic [CW-1:0]  LOAD_LAST   = CW'(NUM_CH - 1);
    localparam logic [BW-1:0]  BURST_LAST  = BW'(BURST_LEN - 1);
    localparam logic [LW-1:0]  LISTEN_LAST = LW'(LISTEN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        BURST  = 3'd2,
        LISTEN = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state;
    logic [OW-1:0]        delay_q;
    logic                 dir_q;
    logic [OW-1:0]        acc;
    logic [CW-1:0]        load_cnt;
    logic [BW-1:0]        burst_cnt;
    logic [LW-1:0]        listen_cnt;
    logic [NUM_CH*OW-1:0] offsets_q;
    logic                 pwm_rst_q;
    logic                 tx_en_q;
    logic                 listen_q;
    logic                 busy_q;
    logic                 done_q;

    logic [OW-1:0] delay_sat;
    logic [OW:0]   acc_sum;
    logic [OW-1:0] acc_next;
    logic [CW-1:0] wr_idx;

    // Delays of a full period or more alias to no steering at all, so clamp them.
    always_comb begin
        delay_sat = (bus.steer_delay_in > PERIOD_M1) ? PERIOD_M1 : bus.steer_delay_in;
    end

    // One extra bit keeps the modulo-PERIOD accumulation exact.
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, delay_q};
        acc_next = acc_sum[OW-1:0];
        if (acc_sum >= PERIOD_W) begin
            acc_next = OW'(acc_sum - PERIOD_W);
        end
    end

    always_comb begin
        wr_idx = dir_q ? (LOAD_LAST - load_cnt) : load_cnt;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            delay_q    <= '0;
            dir_q      <= 1'b0;
            acc        <= '0;
            load_cnt   <= '0;
            burst_cnt  <= '0;
            listen_cnt <= '0;
            offsets_q  <= '0;
            pwm_rst_q  <= 1'b1;
            tx_en_q    <= 1'b0;
            listen_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (state != IDLE && bus.abort_in) begin
            // Abort keeps whatever offsets were already written.
            state      <= IDLE;
            acc        <= '0;
            load_cnt   <= '0;
            burst_cnt  <= '0;
            listen_cnt <= '0;
            pwm_rst_q  <= 1'b1;
            tx_en_q    <= 1'b0;
            listen_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_in && !bus.abort_in) begin
                        state    <= LOAD;
                        delay_q  <= delay_sat;
                        dir_q    <= bus.steer_dir_in;
                        acc      <= '0;
                        load_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (wr_idx == CW'(i)) begin
                            offsets_q[i*OW +: OW] <= acc;
                        end
                    end
                    acc <= acc_next;
                    if (load_cnt == LOAD_LAST) begin
                        state     <= BURST;
                        load_cnt  <= '0;
                        burst_cnt <= '0;
                        pwm_rst_q <= 1'b0;
                        tx_en_q   <= 1'b1;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                BURST: begin
                    if (burst_cnt == BURST_LAST) begin
                        state      <= LISTEN;
                        burst_cnt  <= '0;
                        listen_cnt <= '0;
                        pwm_rst_q  <= 1'b1;
                        tx_en_q    <= 1'b0;
                        listen_q   <= 1'b1;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                LISTEN: begin
                    if (listen_cnt == LISTEN_LAST) begin
                        state      <= DONE;
                        listen_cnt <= '0;
                        listen_q   <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        listen_cnt <= listen_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pwm_rst_q <= 1'b1;
                    tx_en_q   <= 1'b0;
                    listen_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.offsets_out = offsets_q;
    assign bus.pwm_rst_out = pwm_rst_q;
    assign bus.tx_en_out   = tx_en_q;
    assign bus.listen_out  = listen_q;
    assign bus.busy_out    = busy_q;
    assign bus.done_out    = done_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Self-checking bench for tx_burst_sequencer with a small parameter set.
module tb_tx_burst_sequencer;
    localparam int NUM_CH = 4;
    localparam int PERIOD = 100;
    localparam int NUM_PULSES = 2;
    localparam int LISTEN_CYCLES = 50;
    localparam int OW = $clog2(PERIOD);
    localparam int W = NUM_CH * OW;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_off;

    tx_burst_sequencer_if #(.NUM_CH(NUM_CH), .OW(OW)) bus ();

    tx_burst_sequencer #(
        .NUM_CH(NUM_CH),
        .PERIOD_IN_CLOCK_CYCLES(PERIOD),
        .NUM_PULSES(NUM_PULSES),
        .LISTEN_CYCLES(LISTEN_CYCLES)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] model_offsets(input int delay, input bit dir);
        logic [W-1:0] v;
        int d;
        int ch;
        v = '0;
        d = (delay > PERIOD - 1) ? PERIOD - 1 : delay;
        for (int j = 0; j < NUM_CH; j++) begin
            ch = dir ? (NUM_CH - 1 - j) : j;
            v[ch*OW +: OW] = OW'((j * d) % PERIOD);
        end
        return v;
    endfunction

    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic launch(input int delay, input bit dir);
        bus.steer_delay_in = OW'(delay);
        bus.steer_dir_in   = dir;
        bus.start_in       = 1'b1;
        exp_q.push_back(model_offsets(delay, dir));
    endtask

    task automatic advance(input int upto);
        for (int n = 1; n <= upto; n++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            if (n == NUM_CH + 1) begin
                last_off = exp_q.pop_front();
                check("offsets_loaded", bus.offsets_out, last_off);
            end
        end
    endtask

    // Full burst timeline relative to the start cycle T; returns at T+256.
    task automatic run_checks(input bit noise);
        int burst_lo;
        int burst_hi;
        int done_at;
        burst_lo = NUM_CH + 1;
        burst_hi = NUM_CH + NUM_PULSES * PERIOD;
        done_at  = burst_hi + LISTEN_CYCLES + 1;
        for (int n = 1; n <= done_at + 1; n++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            check("busy", bus.busy_out, n <= done_at);
            check("tx_en", bus.tx_en_out, n >= burst_lo && n <= burst_hi);
            check("pwm_rst", bus.pwm_rst_out, !(n >= burst_lo && n <= burst_hi));
            check("listen", bus.listen_out, n > burst_hi && n < done_at);
            check("done", bus.done_out, n == done_at);
            if (n == burst_lo) begin
                last_off = exp_q.pop_front();
                check("offsets_loaded", bus.offsets_out, last_off);
            end
            if (n == done_at) check("offsets_held", bus.offsets_out, last_off);
            if (noise && (n == 2 || n == 100 || n == 230 || n == done_at)) bus.start_in = 1'b1;
        end
    endtask

    initial begin
        int done_cnt;
        checks = 0;
        errors = 0;
        last_off = '0;
        rst = 1'b1;
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        bus.steer_delay_in = '0;
        bus.steer_dir_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_offsets", bus.offsets_out, 0);
        check("rst_pwm_rst", bus.pwm_rst_out, 1);
        check("rst_busy", bus.busy_out, 0);
        check("rst_state", bus.state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        launch(30, 1'b0);  run_checks(1'b0);
        launch(40, 1'b0);  run_checks(1'b0);
        launch(30, 1'b1);  run_checks(1'b0);
        launch(127, 1'b0); run_checks(1'b0);
        launch(30, 1'b0);  run_checks(1'b1);

        // Abort in the middle of the burst
        launch(30, 1'b0);
        advance(100);
        check("pre_abort_tx_en", bus.tx_en_out, 1);
        bus.abort_in = 1'b1;
        @(negedge clk);
        bus.abort_in = 1'b0;
        check("abort_state", bus.state_dbg, 0);
        check("abort_pwm_rst", bus.pwm_rst_out, 1);
        check("abort_tx_en", bus.tx_en_out, 0);
        check("abort_busy", bus.busy_out, 0);
        check("abort_offsets", bus.offsets_out, last_off);
        done_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done_out) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // Abort wins over start in IDLE
        bus.abort_in = 1'b1;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.abort_in = 1'b0;
        bus.start_in = 1'b0;
        check("abort_start_state", bus.state_dbg, 0);
        check("abort_start_busy", bus.busy_out, 0);
        @(negedge clk);
        check("abort_start_busy2", bus.busy_out, 0);

        // Asynchronous reset during LISTEN
        launch(30, 1'b0);
        advance(220);
        check("pre_rst_listen", bus.listen_out, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_offsets", bus.offsets_out, 0);
        check("arst_pwm_rst", bus.pwm_rst_out, 1);
        check("arst_listen", bus.listen_out, 0);
        check("arst_busy", bus.busy_out, 0);
        check("arst_state", bus.state_dbg, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(20, 1'b1); run_checks(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
